ysyx_22050078_lsu: RTL and testbench
====================================

// Module: ysyx_22050078_lsu
// PURPOSE
//  Load/store stage directly downstream of the execute unit, fed through pipe_EX_LS.
//  - Non-memory ops: forwards the execute result to writeback unchanged.
//  - Memory ops: uses the execute result as the byte address and runs a req/gnt/rvalid data-memory transaction.
//  - Builds the 8-bit byte-lane write mask, shifts store data into its lanes, and extracts and sign/zero-extends load data.
//  - Presents one registered result to writeback under a valid/ready handshake.
// PARAMETERS
//  CPU_WIDTH   64  datapath width; address and data width
//  OPT_WIDTH   4   width of the i_lsu_opt encoding
//  RD_WIDTH    5   destination register index width
// PORTS
//  clk          in   1          clock, rising edge
//  rst_n        in   1          asynchronous reset, active low
//  i_valid      in   1          upstream (pipe_EX_LS) has an instruction
//  o_ready      out  1          LSU accepts the instruction this cycle
//  i_exu_res    in   CPU_WIDTH  execute result: the result for ALU ops, the byte address for memory ops
//  i_rs2_data   in   CPU_WIDTH  store data
//  i_lsu_opt    in   OPT_WIDTH  NONE=0,LB,LH,LW,LD,LBU,LHU,LWU,SB,SH,SW,SD=11
//  i_rd_idx     in   RD_WIDTH   destination register index
//  i_rd_wen     in   1          destination write enable
//  o_valid      out  1          result valid toward writeback
//  i_ready      in   1          writeback consumes the result
//  o_wb_data    out  CPU_WIDTH  writeback data
//  o_rd_idx     out  RD_WIDTH   registered copy of i_rd_idx
//  o_rd_wen     out  1          registered copy of i_rd_wen (forced 0 for stores)
//  o_mem_req    out  1          data-memory request
//  o_mem_we     out  1          1 = store, 0 = load
//  o_mem_addr   out  CPU_WIDTH  {addr[63:3],3'b000}, doubleword aligned
//  o_mem_wdata  out  CPU_WIDTH  store data shifted left by addr[2:0]*8
//  o_mem_wmask  out  8          byte-lane enables
//  i_mem_gnt    in   1          memory accepts the request
//  i_mem_rvalid in   1          load data valid (always strictly after the gnt cycle)
//  i_mem_rdata  in   CPU_WIDTH  aligned doubleword of load data
// BEHAVIOUR
//  Reset state: IDLE. o_valid, o_mem_req, o_mem_we, o_rd_wen = 0. All data/address/mask outputs = 0.
//  FSM states: IDLE, REQ, WAIT, RESP.
//  - o_ready = (state==IDLE). An instruction is accepted when i_valid & o_ready; all inputs are latched that cycle.
//  - IDLE, NONE accepted: go to RESP with wb_data = i_exu_res. Latency 1 cycle to o_valid.
//  - IDLE, load/store accepted: go to REQ. o_mem_req is asserted from the next cycle.
//  - REQ: o_mem_req=1. All request fields are held stable until i_mem_gnt.
//    - On gnt with a store: go to RESP.
//    - On gnt with a load: go to WAIT.
//    - o_mem_req drops the cycle after gnt.
//  - WAIT: on i_mem_rvalid, capture the extracted load data and go to RESP.
//  - RESP: o_valid=1 and the outputs are held. On i_ready go to IDLE.
//  - Throughput is at most one instruction per 2 cycles. There is no overlap between RESP and accept.
//  Write mask: base mask shifted left by addr[2:0].
//  - SB: 8'h01. SH: 8'h03. SW: 8'h0F. SD: 8'hFF.
//  Load extract: rdata >> (addr[2:0]*8), truncated to the access size.
//  - LB/LH/LW sign-extend to 64 bits. LBU/LHU/LWU zero-extend. LD passes through.
//  Store result: o_rd_wen=0 and o_wb_data=0.
//  Misaligned accesses (H/W/D not naturally aligned) are issued as-is when the macro is undefined.
//  - Lanes shifted past byte 7 are dropped.
//  i_mem_rvalid in IDLE/REQ/RESP is ignored. i_mem_gnt outside REQ is ignored.
//  Reset mid-transaction: the FSM returns to IDLE asynchronously and o_mem_req drops immediately.
//  - The memory side discards the abandoned request.
//  Undefined i_lsu_opt (12..15): treated as NONE.
// CONFIGURATION
//  Macro YSYX_22050078_LSU_MISALIGN_EN.
//  - Defined: adds port o_misalign (out, 1).
//    - A misaligned memory op skips REQ and goes straight to RESP with o_misalign=1, o_rd_wen=0, o_wb_data=i_exu_res (the faulting address).
//    - No memory request is issued.
//    - o_misalign is 0 for all other results and in reset.
//  - Undefined: no port and no check; behaviour as described above.
// STRUCTURE
//  Shared defines.v gets:
//  - LSU_OPT_WIDTH and the LSU_* opcode macros, also used by IDU.
//  - LSU state encodings.
//  One sub-module, ysyx_22050078_lsu_align (combinational):
//  - addr, opt, rs2, rdata -> wmask, wdata, load_data, misaligned.
//  The FSM and the output registers stay in the top module.
// TESTING
//  - ALU pass: NONE, i_exu_res=64'h1234 -> o_valid in the cycle after accept, o_wb_data=64'h1234, o_mem_req never asserted.
//  - LB sign: addr=0x8000_0003, rdata=64'h0000_0000_8000_0000 -> wb=64'hFFFF_FFFF_FFFF_FF80.
//  - LB zero: addr=0x8000_0001, rdata=64'h0000_0000_8000_0000 -> wb=0.
//  - LWU upper word: addr=0x8000_0004, rdata=64'hDEADBEEF_00000000 -> wb=64'h0000_0000_DEAD_BEEF, mem_addr=0x8000_0000.
//  - SH: addr=0x8000_0006, rs2=64'hABCD -> wmask=8'hC0, wdata=64'hABCD_0000_0000_0000, o_rd_wen=0.
//  - Stalls: gnt withheld 3 cycles and i_ready withheld 2 cycles -> request fields and outputs are stable throughout, o_ready stays 0.
//  - Reset in WAIT: rst_n low -> o_mem_req=0 and o_valid=0 immediately, FSM in IDLE.
//  - Next LD after reset: completes normally.
//  - With the macro defined: LW at 0x8000_0002 -> no o_mem_req, o_misalign=1, wb=0x8000_0002.

Source files
------------

// File: rtl/ysyx_22050078_lsu_pkg.sv
// ============================================================================
// ysyx_22050078_lsu_pkg : LSU opcode encodings, FSM states and opcode helpers
// Revision: 1.0
// ============================================================================
`default_nettype none

package ysyx_22050078_lsu_pkg;

  localparam int LSU_OPT_WIDTH = 4;

  localparam logic [3:0] c_LSU_NONE = 4'd0;
  localparam logic [3:0] c_LSU_LB   = 4'd1;
  localparam logic [3:0] c_LSU_LH   = 4'd2;
  localparam logic [3:0] c_LSU_LW   = 4'd3;
  localparam logic [3:0] c_LSU_LD   = 4'd4;
  localparam logic [3:0] c_LSU_LBU  = 4'd5;
  localparam logic [3:0] c_LSU_LHU  = 4'd6;
  localparam logic [3:0] c_LSU_LWU  = 4'd7;
  localparam logic [3:0] c_LSU_SB   = 4'd8;
  localparam logic [3:0] c_LSU_SH   = 4'd9;
  localparam logic [3:0] c_LSU_SW   = 4'd10;
  localparam logic [3:0] c_LSU_SD   = 4'd11;

  localparam int LSU_ST_WIDTH = 2;
  localparam logic [1:0] c_ST_IDLE = 2'd0;
  localparam logic [1:0] c_ST_REQ  = 2'd1;
  localparam logic [1:0] c_ST_WAIT = 2'd2;
  localparam logic [1:0] c_ST_RESP = 2'd3;

  // Codes 12..15 fall in neither range, so they behave as NONE.
  function automatic logic lsu_is_load(input logic [3:0] opt);
    return (opt >= c_LSU_LB) && (opt <= c_LSU_LWU);
  endfunction

  function automatic logic lsu_is_store(input logic [3:0] opt);
    return (opt >= c_LSU_SB) && (opt <= c_LSU_SD);
  endfunction

endpackage

`default_nettype wire

// File: rtl/ysyx_22050078_lsu_align.sv
// ============================================================================
// ysyx_22050078_lsu_align : byte-lane mask/data alignment and load extraction
// Revision: 1.0
// ============================================================================
`default_nettype none

module ysyx_22050078_lsu_align
  import ysyx_22050078_lsu_pkg::*;
#(
  parameter int CPU_WIDTH = 64
) (
  input  logic [2:0]           i_off,
  input  logic [3:0]           i_opt,
  input  logic [CPU_WIDTH-1:0] i_rs2,
  input  logic [CPU_WIDTH-1:0] i_rdata,
  output logic [7:0]           o_wmask,
  output logic [CPU_WIDTH-1:0] o_wdata,
  output logic [CPU_WIDTH-1:0] o_load_data,
  output logic                 o_misaligned
);

  logic [7:0]           w_base_mask;
  logic [CPU_WIDTH-1:0] w_rshift;

  assign w_rshift = i_rdata >> {i_off, 3'b000};

  always_comb begin
    w_base_mask  = 8'h00;
    o_misaligned = 1'b0;
    o_load_data  = '0;
    case (i_opt)
      c_LSU_SB:  w_base_mask = 8'h01;
      c_LSU_SH: begin w_base_mask = 8'h03; o_misaligned = i_off[0];      end
      c_LSU_SW: begin w_base_mask = 8'h0F; o_misaligned = |i_off[1:0];   end
      c_LSU_SD: begin w_base_mask = 8'hFF; o_misaligned = |i_off;        end
      c_LSU_LB:  o_load_data = {{(CPU_WIDTH-8){w_rshift[7]}}, w_rshift[7:0]};
      c_LSU_LBU: o_load_data = {{(CPU_WIDTH-8){1'b0}}, w_rshift[7:0]};
      c_LSU_LH: begin
        o_load_data  = {{(CPU_WIDTH-16){w_rshift[15]}}, w_rshift[15:0]};
        o_misaligned = i_off[0];
      end
      c_LSU_LHU: begin
        o_load_data  = {{(CPU_WIDTH-16){1'b0}}, w_rshift[15:0]};
        o_misaligned = i_off[0];
      end
      c_LSU_LW: begin
        o_load_data  = {{(CPU_WIDTH-32){w_rshift[31]}}, w_rshift[31:0]};
        o_misaligned = |i_off[1:0];
      end
      c_LSU_LWU: begin
        o_load_data  = {{(CPU_WIDTH-32){1'b0}}, w_rshift[31:0]};
        o_misaligned = |i_off[1:0];
      end
      c_LSU_LD: begin
        o_load_data  = w_rshift;
        o_misaligned = |i_off;
      end
      default: ;
    endcase
  end

  // Lanes shifted past byte 7 fall off the 8-bit result.
  assign o_wmask = w_base_mask << i_off;
  assign o_wdata = lsu_is_store(i_opt) ? (i_rs2 << {i_off, 3'b000}) : '0;

endmodule

`default_nettype wire

// File: rtl/ysyx_22050078_lsu.sv
// ============================================================================
// ysyx_22050078_lsu : load/store stage with req/gnt/rvalid data-memory port
// Optional misaligned-access trap: define YSYX_22050078_LSU_MISALIGN_EN
// Revision: 1.0
// ============================================================================
`default_nettype none

module ysyx_22050078_lsu
  import ysyx_22050078_lsu_pkg::*;
#(
  parameter int CPU_WIDTH = 64,
  parameter int OPT_WIDTH = LSU_OPT_WIDTH,
  parameter int RD_WIDTH  = 5
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_valid,
  output logic                 o_ready,
  input  logic [CPU_WIDTH-1:0] i_exu_res,
  input  logic [CPU_WIDTH-1:0] i_rs2_data,
  input  logic [OPT_WIDTH-1:0] i_lsu_opt,
  input  logic [RD_WIDTH-1:0]  i_rd_idx,
  input  logic                 i_rd_wen,
  output logic                 o_valid,
  input  logic                 i_ready,
  output logic [CPU_WIDTH-1:0] o_wb_data,
  output logic [RD_WIDTH-1:0]  o_rd_idx,
  output logic                 o_rd_wen,
`ifdef YSYX_22050078_LSU_MISALIGN_EN
  output logic                 o_misalign,
`endif
  output logic                 o_mem_req,
  output logic                 o_mem_we,
  output logic [CPU_WIDTH-1:0] o_mem_addr,
  output logic [CPU_WIDTH-1:0] o_mem_wdata,
  output logic [7:0]           o_mem_wmask,
  input  logic                 i_mem_gnt,
  input  logic                 i_mem_rvalid,
  input  logic [CPU_WIDTH-1:0] i_mem_rdata
);

`ifdef YSYX_22050078_LSU_MISALIGN_EN
  localparam logic c_MISALIGN_EN = 1'b1;
`else
  localparam logic c_MISALIGN_EN = 1'b0;
`endif

  logic [LSU_ST_WIDTH-1:0] r_state;
  logic [2:0]              r_off;
  logic [OPT_WIDTH-1:0]    r_opt;

  logic                    w_accept;
  logic                    w_is_load;
  logic                    w_is_store;
  logic                    w_is_mem;
  logic                    w_trap;
  logic [2:0]              w_al_off;
  logic [OPT_WIDTH-1:0]    w_al_opt;
  logic [7:0]              w_wmask;
  logic [CPU_WIDTH-1:0]    w_wdata;
  logic [CPU_WIDTH-1:0]    w_load_data;
  logic                    w_misaligned;

  assign o_ready    = (r_state == c_ST_IDLE);
  assign w_accept   = i_valid & o_ready;
  assign w_is_load  = lsu_is_load(i_lsu_opt);
  assign w_is_store = lsu_is_store(i_lsu_opt);
  assign w_is_mem   = w_is_load | w_is_store;
  assign w_trap     = c_MISALIGN_EN & w_is_mem & w_misaligned;

  // In IDLE the aligner sees the incoming op; afterwards the latched one.
  assign w_al_off = o_ready ? i_exu_res[2:0] : r_off;
  assign w_al_opt = o_ready ? i_lsu_opt      : r_opt;

  ysyx_22050078_lsu_align #(
    .CPU_WIDTH (CPU_WIDTH)
  ) u_align (
    .i_off        (w_al_off),
    .i_opt        (w_al_opt),
    .i_rs2        (i_rs2_data),
    .i_rdata      (i_mem_rdata),
    .o_wmask      (w_wmask),
    .o_wdata      (w_wdata),
    .o_load_data  (w_load_data),
    .o_misaligned (w_misaligned)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= c_ST_IDLE;
      r_off       <= '0;
      r_opt       <= '0;
      o_valid     <= 1'b0;
      o_wb_data   <= '0;
      o_rd_idx    <= '0;
      o_rd_wen    <= 1'b0;
      o_mem_req   <= 1'b0;
      o_mem_we    <= 1'b0;
      o_mem_addr  <= '0;
      o_mem_wdata <= '0;
      o_mem_wmask <= '0;
    end else begin
      case (r_state)
        c_ST_IDLE: begin
          if (w_accept) begin
            r_off    <= i_exu_res[2:0];
            r_opt    <= i_lsu_opt;
            o_rd_idx <= i_rd_idx;
            if (!w_is_mem || w_trap) begin
              o_wb_data <= i_exu_res;
              o_rd_wen  <= i_rd_wen & ~w_trap;
              o_valid   <= 1'b1;
              r_state   <= c_ST_RESP;
            end else begin
              o_mem_req   <= 1'b1;
              o_mem_we    <= w_is_store;
              o_mem_addr  <= {i_exu_res[CPU_WIDTH-1:3], 3'b000};
              o_mem_wdata <= w_wdata;
              o_mem_wmask <= w_wmask;
              o_rd_wen    <= i_rd_wen & ~w_is_store;
              r_state     <= c_ST_REQ;
            end
          end
        end
        c_ST_REQ: begin
          if (i_mem_gnt) begin
            o_mem_req <= 1'b0;
            if (o_mem_we) begin
              o_wb_data <= '0;
              o_valid   <= 1'b1;
              r_state   <= c_ST_RESP;
            end else begin
              r_state   <= c_ST_WAIT;
            end
          end
        end
        c_ST_WAIT: begin
          if (i_mem_rvalid) begin
            o_wb_data <= w_load_data;
            o_valid   <= 1'b1;
            r_state   <= c_ST_RESP;
          end
        end
        c_ST_RESP: begin
          if (i_ready) begin
            o_valid <= 1'b0;
            r_state <= c_ST_IDLE;
          end
        end
        default: r_state <= c_ST_IDLE;
      endcase
    end
  end

`ifdef YSYX_22050078_LSU_MISALIGN_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_misalign <= 1'b0;
    end else if (w_accept) begin
      o_misalign <= w_trap;
    end else if ((r_state == c_ST_RESP) && i_ready) begin
      o_misalign <= 1'b0;
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_ysyx_22050078_lsu.sv
// ============================================================================
// tb_ysyx_22050078_lsu : directed + random self-checking bench for the LSU
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_ysyx_22050078_lsu;

  localparam logic [3:0] c_NONE = 4'd0,  c_LB  = 4'd1,  c_LH  = 4'd2,  c_LW  = 4'd3;
  localparam logic [3:0] c_LD   = 4'd4,  c_LBU = 4'd5,  c_LHU = 4'd6,  c_LWU = 4'd7;
  localparam logic [3:0] c_SB   = 4'd8,  c_SH  = 4'd9,  c_SW  = 4'd10, c_SD  = 4'd11;

`ifdef YSYX_22050078_LSU_MISALIGN_EN
  localparam bit c_MIS_EN = 1'b1;
`else
  localparam bit c_MIS_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_valid, o_ready;
  logic [63:0] i_exu_res, i_rs2_data;
  logic [3:0]  i_lsu_opt;
  logic [4:0]  i_rd_idx;
  logic        i_rd_wen;
  logic        o_valid, i_ready;
  logic [63:0] o_wb_data;
  logic [4:0]  o_rd_idx;
  logic        o_rd_wen;
  logic        o_mem_req, o_mem_we;
  logic [63:0] o_mem_addr, o_mem_wdata;
  logic [7:0]  o_mem_wmask;
  logic        i_mem_gnt, i_mem_rvalid;
  logic [63:0] i_mem_rdata;
`ifdef YSYX_22050078_LSU_MISALIGN_EN
  logic        o_misalign;
`endif

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  ysyx_22050078_lsu dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_valid      (i_valid),
    .o_ready      (o_ready),
    .i_exu_res    (i_exu_res),
    .i_rs2_data   (i_rs2_data),
    .i_lsu_opt    (i_lsu_opt),
    .i_rd_idx     (i_rd_idx),
    .i_rd_wen     (i_rd_wen),
    .o_valid      (o_valid),
    .i_ready      (i_ready),
    .o_wb_data    (o_wb_data),
    .o_rd_idx     (o_rd_idx),
    .o_rd_wen     (o_rd_wen),
`ifdef YSYX_22050078_LSU_MISALIGN_EN
    .o_misalign   (o_misalign),
`endif
    .o_mem_req    (o_mem_req),
    .o_mem_we     (o_mem_we),
    .o_mem_addr   (o_mem_addr),
    .o_mem_wdata  (o_mem_wdata),
    .o_mem_wmask  (o_mem_wmask),
    .i_mem_gnt    (i_mem_gnt),
    .i_mem_rvalid (i_mem_rvalid),
    .i_mem_rdata  (i_mem_rdata)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- reference model: byte-level view of memory accesses ----------------
  function automatic int op_size(input logic [3:0] opt);
    case (opt)
      c_LB, c_LBU, c_SB: return 1;
      c_LH, c_LHU, c_SH: return 2;
      c_LW, c_LWU, c_SW: return 4;
      c_LD, c_SD:        return 8;
      default:           return 0;
    endcase
  endfunction

  function automatic bit op_load(input logic [3:0] opt);
    return opt inside {c_LB, c_LH, c_LW, c_LD, c_LBU, c_LHU, c_LWU};
  endfunction

  function automatic bit op_store(input logic [3:0] opt);
    return opt inside {c_SB, c_SH, c_SW, c_SD};
  endfunction

  function automatic logic [63:0] model_load(input logic [3:0] opt, input int off,
                                             input logic [63:0] rdata);
    logic [63:0] r;
    int n;
    r = '0;
    n = op_size(opt);
    for (int i = 0; i < n; i++)
      if (off + i < 8) r[8*i +: 8] = rdata[8*(off+i) +: 8];
    if ((opt inside {c_LB, c_LH, c_LW}) && r[8*n-1])
      for (int i = 8*n; i < 64; i++) r[i] = 1'b1;
    return r;
  endfunction

  function automatic logic [7:0] model_wmask(input logic [3:0] opt, input int off);
    logic [7:0] m;
    m = '0;
    for (int i = 0; i < op_size(opt); i++)
      if (off + i < 8) m[off+i] = 1'b1;
    return m;
  endfunction

  function automatic logic [63:0] model_wdata(input logic [63:0] rs2, input int off);
    logic [63:0] d;
    d = '0;
    for (int i = off; i < 8; i++) d[8*i +: 8] = rs2[8*(i-off) +: 8];
    return d;
  endfunction

  // One instruction end to end, with configurable gnt / rvalid / ready stalls.
  task automatic run_op(input string nm, input logic [3:0] opt, input logic [63:0] addr,
                        input logic [63:0] rs2, input logic [63:0] rdata,
                        input int gnt_dly, input int rv_dly, input int rdy_dly);
    int          off, sz;
    bit          ld, st, mem, trap;
    logic [4:0]  rd;
    logic        wen;
    logic [63:0] e_wb;
    logic        e_wen;
    off  = int'(addr[2:0]);
    sz   = op_size(opt);
    ld   = op_load(opt);
    st   = op_store(opt);
    mem  = ld || st;
    trap = c_MIS_EN && mem && ((off % sz) != 0);
    rd   = 5'($urandom);
    wen  = 1'($urandom);
    e_wb  = (!mem || trap) ? addr : (st ? 64'd0 : model_load(opt, off, rdata));
    e_wen = (!mem) ? wen : ((st || trap) ? 1'b0 : wen);

    check({nm, ".ready_idle"}, o_ready, 1'b1);
    i_valid = 1'b1; i_exu_res = addr; i_rs2_data = rs2;
    i_lsu_opt = opt; i_rd_idx = rd; i_rd_wen = wen;
    tick();
    i_valid = 1'b0; i_exu_res = {$urandom, $urandom}; i_rs2_data = {$urandom, $urandom};
    i_lsu_opt = 4'($urandom); i_rd_idx = 5'($urandom); i_rd_wen = 1'($urandom);

    if (mem && !trap) begin
      for (int c = 0; c <= gnt_dly; c++) begin
        check({nm, ".req"}, o_mem_req, 1'b1);
        check({nm, ".we"}, o_mem_we, st);
        check({nm, ".addr"}, o_mem_addr, {addr[63:3], 3'b000});
        if (st) begin
          check({nm, ".wmask"}, o_mem_wmask, model_wmask(opt, off));
          check({nm, ".wdata"}, o_mem_wdata, model_wdata(rs2, off));
        end
        check({nm, ".ready_busy"}, o_ready, 1'b0);
        check({nm, ".valid_early"}, o_valid, 1'b0);
        if (c == gnt_dly) i_mem_gnt = 1'b1;
        else begin i_mem_rvalid = 1'($urandom); i_mem_rdata = {$urandom, $urandom}; end
        tick();
        i_mem_gnt = 1'b0; i_mem_rvalid = 1'b0;
      end
      check({nm, ".req_drop"}, o_mem_req, 1'b0);
      if (ld) begin
        for (int c = 0; c <= rv_dly; c++) begin
          check({nm, ".valid_wait"}, o_valid, 1'b0);
          if (c == rv_dly) begin i_mem_rvalid = 1'b1; i_mem_rdata = rdata; end
          else i_mem_gnt = 1'($urandom);
          tick();
          i_mem_rvalid = 1'b0; i_mem_gnt = 1'b0; i_mem_rdata = {$urandom, $urandom};
        end
      end
    end

    for (int c = 0; c <= rdy_dly; c++) begin
      check({nm, ".valid"}, o_valid, 1'b1);
      check({nm, ".wb"}, o_wb_data, e_wb);
      check({nm, ".rd_idx"}, o_rd_idx, rd);
      check({nm, ".rd_wen"}, o_rd_wen, e_wen);
      check({nm, ".ready_resp"}, o_ready, 1'b0);
      check({nm, ".req_resp"}, o_mem_req, 1'b0);
`ifdef YSYX_22050078_LSU_MISALIGN_EN
      check({nm, ".misalign"}, o_misalign, trap);
`endif
      i_ready = (c == rdy_dly);
      i_mem_rvalid = 1'($urandom);
      tick();
      i_ready = 1'b0; i_mem_rvalid = 1'b0;
    end
    check({nm, ".valid_done"}, o_valid, 1'b0);
    check({nm, ".ready_done"}, o_ready, 1'b1);
  endtask

  initial begin
    rst_n = 1'b0; i_valid = 1'b0; i_exu_res = '0; i_rs2_data = '0; i_lsu_opt = '0;
    i_rd_idx = '0; i_rd_wen = 1'b0; i_ready = 1'b0; i_mem_gnt = 1'b0;
    i_mem_rvalid = 1'b0; i_mem_rdata = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst.valid", o_valid, 1'b0);
    check("rst.req", o_mem_req, 1'b0);
    check("rst.we", o_mem_we, 1'b0);
    check("rst.rd_wen", o_rd_wen, 1'b0);
    check("rst.wb", o_wb_data, 64'd0);
    check("rst.rd_idx", o_rd_idx, 5'd0);
    check("rst.addr", o_mem_addr, 64'd0);
    check("rst.wdata", o_mem_wdata, 64'd0);
    check("rst.wmask", o_mem_wmask, 8'd0);
    check("rst.ready", o_ready, 1'b1);
`ifdef YSYX_22050078_LSU_MISALIGN_EN
    check("rst.misalign", o_misalign, 1'b0);
`endif
    rst_n = 1'b1;
    tick();

    run_op("alu",     c_NONE, 64'h1234,      64'h5555, 64'h0, 0, 0, 0);
    run_op("lb_sign", c_LB,   64'h8000_0003, 64'h0,    64'h0000_0000_8000_0000, 0, 0, 0);
    run_op("lb_zero", c_LB,   64'h8000_0001, 64'h0,    64'h0000_0000_8000_0000, 1, 1, 0);
    run_op("lwu_up",  c_LWU,  64'h8000_0004, 64'h0,    64'hDEAD_BEEF_0000_0000, 0, 0, 0);
    run_op("sh",      c_SH,   64'h8000_0006, 64'hABCD, 64'h0, 0, 0, 0);
    run_op("stall_sd", c_SD,  64'h8000_0010, 64'h0123_4567_89AB_CDEF, 64'h0, 3, 0, 2);
    run_op("stall_ld", c_LD,  64'h8000_0018, 64'h0,    64'hFEDC_BA98_7654_3210, 3, 2, 2);
    run_op("sw_edge", c_SW,   64'h8000_0006, 64'h1122_3344, 64'h0, 0, 0, 0);
    run_op("lw_edge", c_LW,   64'h8000_0006, 64'h0,    64'h8899_0000_0000_0000, 0, 0, 1);
    run_op("opt_inv", 4'd13,  64'hCAFE_F00D, 64'h0,    64'h0, 0, 0, 0);
`ifdef YSYX_22050078_LSU_MISALIGN_EN
    run_op("mis_lw",  c_LW,   64'h8000_0002, 64'h0,    64'hFFFF_FFFF_FFFF_FFFF, 0, 0, 0);
`endif

    // Reset while REQ is pending: request must vanish without a clock edge.
    i_valid = 1'b1; i_exu_res = 64'h8000_0020; i_lsu_opt = c_LD; i_rd_idx = 5'd3; i_rd_wen = 1'b1;
    tick();
    i_valid = 1'b0;
    check("rstreq.req_before", o_mem_req, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check("rstreq.req", o_mem_req, 1'b0);
    check("rstreq.ready", o_ready, 1'b1);
    #2 rst_n = 1'b1;
    tick();

    // Reset while WAITing for load data.
    i_valid = 1'b1;
    tick();
    i_valid = 1'b0; i_mem_gnt = 1'b1;
    tick();
    i_mem_gnt = 1'b0;
    check("rstwait.ready_before", o_ready, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    check("rstwait.req", o_mem_req, 1'b0);
    check("rstwait.valid", o_valid, 1'b0);
    check("rstwait.ready", o_ready, 1'b1);
    #2 rst_n = 1'b1;
    tick();
    run_op("ld_after_rst", c_LD, 64'h8000_0028, 64'h0, 64'h0F0E_0D0C_0B0A_0908, 1, 1, 0);

    for (int k = 0; k < 40; k++) begin
      run_op("rand", 4'($urandom_range(0, 15)), {$urandom, $urandom}, {$urandom, $urandom},
             {$urandom, $urandom}, $urandom_range(0, 3), $urandom_range(0, 3),
             $urandom_range(0, 3));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
